// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller and its multiply/divide unit.
// Holds the Operation codes, ALUOp classes, Funct7 patterns, the M-extension
// operation enum (encoded exactly as Funct3) and the sequencer state enum.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BGE  = 4'b1001,
    OP_BNE  = 4'b1010,
    OP_BGEU = 4'b1011,
    OP_SLT  = 4'b1100,  // also used for BLT
    OP_SLTU = 4'b1101,
    OP_BLTU = 4'b1110,
    OP_PASS = 4'b1111   // JAL/LUI
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative RV32M-style multiply/divide datapath, one bit per cycle.
// Operands are reduced to magnitudes at start, the product/quotient is built
// by shift-add or restoring division, and signs are applied on the way out.
// Ports:
//   clk, reset        clock, synchronous active-high reset (counter only)
//   start             load operands/op and begin iterating
//   op                M operation (Funct3 encoding)
//   src_a, src_b      operands
//   done              iterations complete, or special case when EARLY_OUT
//   res               final, sign-corrected result (valid while done)
module muldiv_core
  import alu_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  m_op_e           op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_END  = CW'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]   cnt_q, cnt_d;
  m_op_e           op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic            neg_q, neg_d, negr_q, negr_d, dz_q, dz_d, ovf_q, ovf_d;

  logic            a_sgn, b_sgn, is_div, run_div, div_ge;
  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign a_sgn   = src_a[XLEN-1] && (op inside {M_MULH, M_MULHSU, M_DIV, M_REM});
  assign b_sgn   = src_b[XLEN-1] && (op inside {M_MULH, M_DIV, M_REM});
  assign a_mag   = a_sgn ? -src_a : src_a;
  assign b_mag   = b_sgn ? -src_b : src_b;
  assign is_div  = op inside {M_DIV, M_DIVU, M_REM, M_REMU};
  assign run_div = op_q inside {M_DIV, M_DIVU, M_REM, M_REMU};

  // Multiply: {hi,lo} holds partial product above the unused multiplier bits.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign div_rs   = {hi_q, lo_q[XLEN-1]};
  assign div_ge   = (div_rs >= {1'b0, opd_q});
  assign div_diff = div_rs - {1'b0, opd_q};

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    opd_d  = opd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    neg_d  = neg_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    if (start) begin
      op_d   = op;
      a_d    = src_a;
      neg_d  = a_sgn ^ b_sgn;
      negr_d = a_sgn;
      dz_d   = is_div && (src_b == '0);
      ovf_d  = (op inside {M_DIV, M_REM}) && (src_a == MOST_NEG) && (src_b == '1);
      hi_d   = '0;
      cnt_d  = '0;
      lo_d   = is_div ? a_mag : b_mag;
      opd_d  = is_div ? b_mag : a_mag;
    end else if (cnt_q != CNT_END) begin
      cnt_d = cnt_q + CW'(1);
      if (run_div) begin
        hi_d = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], div_ge};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_END;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    opd_q  <= opd_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    neg_q  <= neg_d;
    negr_q <= negr_d;
    dz_q   <= dz_d;
    ovf_q  <= ovf_d;
  end

  // Sign fixup and special-case override on the final magnitudes.
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = negr_q ? -hi_q : hi_q;

  always_comb begin
    res = prod_fix[XLEN-1:0];
    case (op_q)
      M_MUL:                     res = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: res = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             res = dz_q ? '1 : (ovf_q ? a_q : quo_fix);
      default:                   res = dz_q ? a_q : (ovf_q ? '0 : rem_fix);
    endcase
  end

  assign done = (cnt_q == CNT_END) || ((EARLY_OUT != 0) && (dz_q || ovf_q));

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU controller with an attached iterative M-extension unit.
// Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation, flags M ops via
// m_sel, and sequences muldiv_core through IDLE -> BUSY -> DONE with
// valid/ready handshakes on both sides.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   ALUOp, Funct7, Funct3    instruction class and function fields
//   rtype                    instruction is R-type (qualifies M decode)
//   Operation, m_sel         combinational decode outputs
//   in_valid/in_ready        request handshake (ready only in IDLE)
//   src_a, src_b             M operands, latched at acceptance
//   out_valid/out_ready      result handshake (valid only in DONE)
//   result                   registered M result
//   busy                     any state other than IDLE
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            rtype,
  output logic [3:0]      Operation,
  output logic            m_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  alu_op_e         op;
  m_op_e           m_op;
  logic            accept, core_done;
  logic [XLEN-1:0] core_res;

  assign m_sel = (ALUOp == ALUOP_RTYPE) && rtype && (Funct7 == F7_MULDIV);

  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      ALUOP_MEM:  op = OP_ADD;
      ALUOP_JUMP: op = OP_PASS;
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_SLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_BEQ;   // 000 and the unused 010/011
        endcase
      end
      default: begin
        if (!m_sel) begin
          case (Funct3)
            // SUB only exists as R-type; ADDI may carry 0100000 in its immediate.
            3'b000:  op = (rtype && (Funct7 == F7_ALT)) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            // SRAI encodes 0100000 in imm[11:5], so no rtype qualification here.
            3'b101:  op = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
    endcase
  end

  assign Operation = op;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready && m_sel;
  assign m_op      = m_op_e'(Funct3);

  muldiv_core #(
    .XLEN      (XLEN),
    .EARLY_OUT (EARLY_OUT)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .op    (m_op),
    .src_a (src_a),
    .src_b (src_b),
    .done  (core_done),
    .res   (core_res)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: begin
        if (core_done) begin
          state_d  = S_DONE;
          result_d = core_res;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule
